// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the restoring divider:
//   - DEFAULT_WIDTH : default operand/result width
//   - CNT_WIDTH     : iteration counter width for DEFAULT_WIDTH (holds 0..WIDTH)
//   - state_t       : controller states IDLE / BUSY / DONE
// ---------------------------------------------------------------------------
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must represent the value WIDTH itself, hence WIDTH+1 codes.
  localparam int CNT_WIDTH = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift {rem, dvd} left by one,
// trial-subtract the divisor from the shifted remainder, and keep the
// difference (quotient bit 1) or restore the shifted value (quotient bit 0).
// Ports:
//   rem_in  [WIDTH-1:0] : partial remainder before the step
//   dvd_in  [WIDTH-1:0] : dividend/quotient shift register before the step
//   dsr     [WIDTH-1:0] : divisor (magnitude)
//   rem_out [WIDTH-1:0] : partial remainder after the step
//   dvd_out [WIDTH-1:0] : shift register after the step, new quotient bit in LSB
// ---------------------------------------------------------------------------
import divider_pkg::*;

module div_step #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dvd_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Shift, trial-subtract and restore for a single quotient bit.
  always_comb begin
    shifted = {rem_in, dvd_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, dsr});
    // When the subtraction fits, the true difference is below the divisor,
    // so the low WIDTH bits of the difference are exact.
    diff    = shifted[WIDTH-1:0] - dsr;
    if (fits) begin
      rem_out = diff;
    end else begin
      rem_out = shifted[WIDTH-1:0];
    end
    dvd_out = {dvd_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
// Multi-cycle restoring divider, one quotient bit per clock, WIDTH cycles
// from start acceptance to valid. A zero divisor bypasses the iteration and
// reports quotient = all ones, remainder = dividend, div_by_zero = 1 one cycle
// after acceptance.
// Optional feature: define SIGNED_DIV_EN for two's-complement operands
// (magnitudes are divided, quotient truncates toward zero, remainder takes
// the dividend's sign). Without it the divider is purely unsigned.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request, accepted in IDLE or DONE
//   dividend    in   [WIDTH-1:0] numerator, captured on acceptance
//   divisor     in   [WIDTH-1:0] denominator, captured on acceptance
//   quotient    out  [WIDTH-1:0] registered result, held until next completion
//   remainder   out  [WIDTH-1:0] registered result, held until next completion
//   valid       out  one-cycle pulse when results are written
//   busy        out  high exactly while in BUSY
//   div_by_zero out  last completed operation had a zero divisor
// ---------------------------------------------------------------------------
import divider_pkg::*;

module restoring_divider #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] part_rem, part_rem_next;
  logic [WIDTH-1:0] work, work_next;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr, dsr_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             zero_pend, zero_pend_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;
  logic             valid_next, busy_next, dbz_next;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] q_final, r_final;
  logic [WIDTH-1:0] step_rem, step_work;
`ifdef SIGNED_DIV_EN
  logic             neg_q, neg_q_next;
  logic             neg_r, neg_r_next;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (part_rem),
    .dvd_in  (work),
    .dsr     (dsr),
    .rem_out (step_rem),
    .dvd_out (step_work)
  );

  // Operand conditioning and final result sign fix-up.
  always_comb begin
`ifdef SIGNED_DIV_EN
    if (dividend[WIDTH-1]) begin
      op_a = ~dividend + WIDTH'(1);
    end else begin
      op_a = dividend;
    end
    if (divisor[WIDTH-1]) begin
      op_b = ~divisor + WIDTH'(1);
    end else begin
      op_b = divisor;
    end
    if (neg_q) begin
      q_final = ~step_work + WIDTH'(1);
    end else begin
      q_final = step_work;
    end
    if (neg_r) begin
      r_final = ~step_rem + WIDTH'(1);
    end else begin
      r_final = step_rem;
    end
`else
    op_a    = dividend;
    op_b    = divisor;
    q_final = step_work;
    r_final = step_rem;
`endif
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next     = state;
    part_rem_next  = part_rem;
    work_next      = work;
    dsr_next       = dsr;
    cnt_next       = cnt;
    zero_pend_next = zero_pend;
    quotient_next  = quotient;
    remainder_next = remainder;
    valid_next     = 1'b0;
    dbz_next       = div_by_zero;
    accept         = 1'b0;
`ifdef SIGNED_DIV_EN
    neg_q_next     = neg_q;
    neg_r_next     = neg_r;
`endif

    case (state)
      IDLE: begin
        // A pending zero-divisor result takes the cycle after acceptance;
        // a start seen in that same cycle is not accepted.
        if (zero_pend) begin
          quotient_next  = {WIDTH{1'b1}};
          remainder_next = work;
          dbz_next       = 1'b1;
          valid_next     = 1'b1;
          zero_pend_next = 1'b0;
          state_next     = DONE;
        end else if (start) begin
          accept = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        part_rem_next = step_rem;
        work_next     = step_work;
        cnt_next      = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          quotient_next  = q_final;
          remainder_next = r_final;
          dbz_next       = 1'b0;
          valid_next     = 1'b1;
          state_next     = DONE;
        end else begin
          state_next = BUSY;
        end
      end
      DONE: begin
        if (start) begin
          accept = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      dsr_next      = op_b;
      part_rem_next = {WIDTH{1'b0}};
      if (divisor == {WIDTH{1'b0}}) begin
        // Remainder must report the raw dividend, so keep it unconditioned.
        work_next      = dividend;
        cnt_next       = CW'(0);
        zero_pend_next = 1'b1;
        state_next     = IDLE;
      end else begin
        work_next      = op_a;
        cnt_next       = CW'(WIDTH);
        zero_pend_next = 1'b0;
        state_next     = BUSY;
      end
`ifdef SIGNED_DIV_EN
      neg_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_next = dividend[WIDTH-1];
`endif
    end else begin
      zero_pend_next = zero_pend_next;
    end

    busy_next = (state_next == BUSY);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      part_rem    <= {WIDTH{1'b0}};
      work        <= {WIDTH{1'b0}};
      dsr         <= {WIDTH{1'b0}};
      cnt         <= CW'(0);
      zero_pend   <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      part_rem    <= part_rem_next;
      work        <= work_next;
      dsr         <= dsr_next;
      cnt         <= cnt_next;
      zero_pend   <= zero_pend_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      valid       <= valid_next;
      busy        <= busy_next;
      div_by_zero <= dbz_next;
`ifdef SIGNED_DIV_EN
      neg_q       <= neg_q_next;
      neg_r       <= neg_r_next;
`endif
    end
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
- REQ-001: Parameter WIDTH SHALL be: WIDTH, default 8, operand/result bit width.
- REQ-002: Port clk SHALL be: clk  input  1  single rising-edge clock.
- REQ-003: Port rst_n SHALL be: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: Port start SHALL be: start  input  1  request; sampled on the rising clk edge.
- REQ-005: Port dividend SHALL be: dividend  input  WIDTH  numerator; captured when start is accepted.
- REQ-006: Port divisor SHALL be: divisor  input  WIDTH  denominator; captured when start is accepted.
- REQ-007: Port quotient SHALL be: quotient  output  WIDTH  registered result.
- REQ-008: Port remainder SHALL be: remainder  output  WIDTH  registered result.
- REQ-009: Port valid SHALL be: valid  output  1  one-cycle pulse; results are final.
- REQ-010: Port busy SHALL be: busy  output  1  high while a division is in progress.
- REQ-011: Port div_by_zero SHALL be: div_by_zero  output  1  last operation had divisor == 0.

Function
- REQ-012: The FSM SHALL have states IDLE, BUSY and DONE; reset state is IDLE.
- REQ-013: Start acceptance SHALL occur in IDLE or DONE when start=1 at edge E0: latch the operands, clear the partial remainder, load the iteration count with WIDTH, go to BUSY.
- REQ-014: BUSY SHALL perform one restoring step per cycle: shift {rem, dvd} left 1, trial-subtract divisor, set quotient bit to 1 and keep the difference if non-negative, else restore.
- REQ-015: After the WIDTH-th step (edge E0+WIDTH), quotient and remainder SHALL update, valid=1 and the state SHALL become DONE; total latency is WIDTH cycles from start.
- REQ-016: DONE SHALL last exactly one cycle, then return to IDLE; valid SHALL drop at that edge unless a new start is accepted.
- REQ-017: quotient, remainder and div_by_zero SHALL hold their values until the next operation completes.
- REQ-018: busy SHALL be 1 exactly in BUSY.
- REQ-019: start in BUSY SHALL be ignored, with no queuing.
- REQ-020: Divisor == 0 at acceptance SHALL skip BUSY: at E0+1 quotient = all ones, remainder = dividend, div_by_zero=1, valid=1, state DONE.
- REQ-021: A non-zero divisor SHALL clear div_by_zero when the result is written.
- REQ-022: Unsigned results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor; no internal width beyond WIDTH+1 bits.

Reset
- REQ-023: rst_n=0 SHALL immediately force IDLE, quotient=0, remainder=0, valid=0, busy=0, div_by_zero=0 and the count to 0, including mid-operation.
- REQ-024: After rst_n deasserts, the first accepted start SHALL begin a clean operation with no residue from the aborted one.

Configuration
- REQ-025: With macro SIGNED_DIV_EN defined, operands SHALL be two's complement: divide magnitudes, quotient truncated toward zero, negated when the operand signs differ, remainder sign follows the dividend; latency unchanged.
- REQ-026: With SIGNED_DIV_EN defined, most-negative / -1 SHALL produce quotient = most-negative (wrap) and remainder 0, and divide-by-zero SHALL give quotient = -1 and remainder = dividend.
- REQ-027: Without SIGNED_DIV_EN, operands SHALL be unsigned, with no sign logic synthesized.

Structure
- REQ-028: A package divider_pkg SHALL hold the state enum (IDLE/BUSY/DONE), the default WIDTH constant and the count-width constant.
- REQ-029: One combinational sub-module div_step SHALL implement a single shift/trial-subtract/restore step, instantiated once and reused every cycle.

Verification
- REQ-030: Scenario SHALL be: dividend=80, divisor=38, start 1 cycle -> after 8 cycles valid=1, quotient=2, remainder=4, div_by_zero=0.
- REQ-031: Scenario SHALL be: 255/1 then 7/9 back-to-back, start in DONE -> 255 r 0, then 0 r 7; each valid is a single pulse.
- REQ-032: Scenario SHALL be: 38/0 -> at the next cycle valid=1, quotient=8'hFF, remainder=38, div_by_zero=1, busy never 1.
- REQ-033: Scenario SHALL be: start again 3 cycles into BUSY with different operands -> ignored; the original result appears at the original cycle.
- REQ-034: Scenario SHALL be: rst_n pulsed low at BUSY step 4 -> all outputs 0 immediately, no valid; a following 100/7 gives 14 r 2.
- REQ-035: Scenario SHALL be: with SIGNED_DIV_EN, -80/38 -> quotient 8'hFE (-2), remainder 8'hFC (-4); -128/-1 -> 8'h80 r 0.
